debounce_sync: RTL and testbench

//  - Conditions a raw asynchronous input (switch, button or off-board strobe) into a clean, glitch-free level.
//  - Sits directly upstream of the D flip-flop stage: d_out drives that stage's D input.
//  - Provides a multi-stage synchronizer, a counter-based debounce FSM, and single-cycle rise/fall event pulses.

---
 rtl/debounce_sync.sv | 110 +++++++++++
 tb/tb_debounce_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Raw-input conditioner: N-flop synchronizer, counter-qualified debounce FSM,
// registered level output plus one-cycle rise/fall event pulses and busy flag.
module debounce_sync #(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   d_q, d_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  // Only the last synchronizer stage is ever observed downstream.
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        // A bounce drops back to idle; qualification restarts from scratch.
        if (!s) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HIGH;
          d_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LOW;
          d_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign d_out      = d_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed scenario bench for debounce_sync with default parameters, plus a
// bounded random run checked against an independent run-length model.
module tb_debounce_sync;

  localparam int DEB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b0;
  logic d_out, rise_pulse, fall_pulse, busy;

  int checks = 0;
  int errors = 0;

  debounce_sync dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .d_out      (d_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream D flip-flop stage fed by d_out.
  logic dff_q;
  always @(posedge clk) dff_q <= d_out;

  // Reference: count consecutive synchronized samples disagreeing with the level.
  logic [1:0] m_sync;
  logic       m_d, m_rise, m_fall;
  int         m_run;
  always @(posedge clk) begin
    if (rst) begin
      m_sync <= 2'b00; m_d <= 1'b0; m_run <= 0; m_rise <= 1'b0; m_fall <= 1'b0;
    end else begin
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      m_sync <= {m_sync[0], raw_in};
      if (m_sync[1] != m_d) begin
        if (m_run == DEB) begin
          m_d <= ~m_d; m_run <= 0;
          if (m_d) m_fall <= 1'b1; else m_rise <= 1'b1;
        end else m_run <= m_run + 1;
      end else m_run <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b%b%b%b exp=0000", i, d_out, rise_pulse, fall_pulse, busy);
      end
    end
    rst = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 17) begin
        checks++;
        if (d_out !== 1'b0) begin errors++; $display("FAIL reset_rel_e17 d_out=%b exp=0", d_out); end
      end
      if (e == 18) begin
        checks++;
        if ({d_out, rise_pulse} !== 2'b11) begin
          errors++; $display("FAIL reset_rel_rise d_out,rise=%b%b exp=11", d_out, rise_pulse);
        end
      end
      if (e == 19) begin
        checks++;
        if (rise_pulse !== 1'b0) begin errors++; $display("FAIL reset_rel_e19 rise=%b exp=0", rise_pulse); end
      end
    end
    // accepted-high level must also clear on reset
    rst = 1'b1; raw_in = 1'b0;
    tick();
    checks++;
    if ({d_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_from_high got=%b%b%b%b exp=0000", d_out, rise_pulse, fall_pulse, busy);
    end
    rst = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_rise();
    int rises = 0;
    raw_in = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (rise_pulse === 1'b1) rises++;
      if (e == 17) begin
        checks++;
        if (d_out !== 1'b0) begin errors++; $display("FAIL rise_e17 d_out=%b exp=0", d_out); end
      end
      if (e == 18) begin
        checks++;
        if ({d_out, rise_pulse, busy} !== 3'b110) begin
          errors++; $display("FAIL rise_e18 d_out,rise,busy=%b%b%b exp=110", d_out, rise_pulse, busy);
        end
      end
      if (e >= 3 && e <= 17) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy e=%0d busy=%b exp=1", e, busy); end
      end
    end
    checks++;
    if (rises != 1 || d_out !== 1'b1) begin
      errors++; $display("FAIL rise_count rises=%0d d_out=%b exp=1,1", rises, d_out);
    end
  endtask

  task automatic test_bounce_fall();
    int rises = 0, falls = 0;
    for (int i = 0; i < 30; i++) begin
      raw_in = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (rise_pulse === 1'b1) rises++;
      if (fall_pulse === 1'b1) falls++;
    end
    checks++;
    if (d_out !== 1'b1 || falls != 0) begin
      errors++; $display("FAIL bounce_hold d_out=%b falls=%0d exp=1,0", d_out, falls);
    end
    raw_in = 1'b0;
    for (int e = 0; e <= 25; e++) begin
      tick();
      if (rise_pulse === 1'b1) rises++;
      if (fall_pulse === 1'b1) falls++;
      if (e == 17) begin
        checks++;
        if ({d_out, fall_pulse} !== 2'b10) begin
          errors++; $display("FAIL bounce_e17 d_out,fall=%b%b exp=10", d_out, fall_pulse);
        end
      end
      if (e == 18) begin
        checks++;
        if ({d_out, fall_pulse} !== 2'b01) begin
          errors++; $display("FAIL bounce_e18 d_out,fall=%b%b exp=01", d_out, fall_pulse);
        end
      end
    end
    checks++;
    if (falls != 1 || rises != 0) begin
      errors++; $display("FAIL bounce_count falls=%0d rises=%0d exp=1,0", falls, rises);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int busy_seen = 0;
    raw_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (busy === 1'b1) busy_seen++;
      if (rise_pulse === 1'b1 || fall_pulse === 1'b1 || d_out !== 1'b0) pulses++;
    end
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rise_pulse === 1'b1 || fall_pulse === 1'b1 || d_out !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL glitch_out bad_cycles=%0d exp=0", pulses); end
    checks++;
    if (busy !== 1'b0 || busy_seen == 0) begin
      errors++; $display("FAIL glitch_busy busy=%b seen=%0d exp=0,>0", busy, busy_seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rises = 0;
    raw_in = 1'b1;
    for (int e = 0; e <= 12; e++) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_pre busy=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    checks++;
    if ({d_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
      errors++; $display("FAIL midwait_rst got=%b%b%b%b exp=0000", d_out, rise_pulse, fall_pulse, busy);
    end
    rst = 1'b0; raw_in = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (rise_pulse === 1'b1 || d_out !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin errors++; $display("FAIL midwait_after bad_cycles=%0d exp=0", rises); end
  endtask

  task automatic test_random();
    logic prev_d;
    int   cyc = 0, rises = 0, d_rises = 0, falls = 0, d_falls = 0;
    tick();
    prev_d = d_out;
    while (cyc < 1500) begin
      raw_in = 1'($urandom_range(0, 1));
      for (int k = $urandom_range(1, 25); k > 0; k--) begin
        tick();
        cyc++;
        checks++;
        if ({d_out, rise_pulse, fall_pulse, busy} !== {m_d, m_rise, m_fall, (m_run != 0)}) begin
          errors++;
          $display("FAIL rand_model cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc, d_out, rise_pulse,
                   fall_pulse, busy, m_d, m_rise, m_fall, (m_run != 0));
        end
        checks++;
        if (dff_q !== prev_d) begin
          errors++; $display("FAIL rand_dff cyc=%0d q=%b exp=%b", cyc, dff_q, prev_d);
        end
        if (rise_pulse === 1'b1) rises++;
        if (fall_pulse === 1'b1) falls++;
        if (!prev_d && d_out) d_rises++;
        if (prev_d && !d_out) d_falls++;
        prev_d = d_out;
      end
    end
    checks++;
    if (rises != d_rises || falls != d_falls || d_rises == 0) begin
      errors++;
      $display("FAIL rand_pulses rise=%0d/%0d fall=%0d/%0d", rises, d_rises, falls, d_falls);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_bounce_fall();
    test_glitch();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
